sfif_tx_arb: RTL and testbench
==============================

// Module: sfif_tx_arb
// PURPOSE
//  Arbitrates and sequences the shared 64-bit TX TLP path (tx64_* into the 64b->16b bridge) between three requesters:
//  0 = posted (MWr), 1 = non-posted (MRd), 2 = completion (CplD). Gates each source on credit/tag availability.
//  Issues tx_req to the core, owns the path until the granted TLP's last beat, then enforces an inter-packet gap.
//  Sits between the per-source TLP FIFOs and bridge_64b_to_16b, alongside sfif_ca / sfif_tag in the clk_125 domain.
// PARAMETERS
//  IPG_CYC      4      idle cycles inserted after each TLP end (0 = back-to-back allowed)
//  TMO_CYC      1024   cycles in REQ without tx_rdy before abandoning the request
//  CPL_PRIO     1      1 = completions win over RR when eligible; 0 = pure round-robin
// PORTS
//  clk_125       in   1    core clock
//  sfif_rstn     in   1    async active-low reset
//  src_req       in   3    source has a full TLP staged (held until its end beat is consumed)
//  src_data      in   192  {src2,src1,src0} 64-bit beats, valid while src_req
//  src_st        in   3    first beat of TLP on src_data
//  src_end       in   3    last beat of TLP on src_data
//  src_dwen      in   3    last beat carries only upper DW
//  src_gnt       out  3    one-hot grant, registered
//  src_rd        out  3    beat consumed = src_gnt & {3{tx_val}} (combinational)
//  cr_ok_p       in   1    posted header/data credits sufficient (from sfif_ca)
//  cr_ok_np      in   1    non-posted credits sufficient
//  tag_avail     in   1    free tag exists (from sfif_tag)
//  tx_req        out  1    request to core
//  tx_rdy        in   1    core grant
//  tx_val        in   1    bridge accepted current 64-bit beat
//  tx64_data     out  64   muxed beat of granted source
//  tx64_st/end   out  1/1  muxed src_st/src_end of granted source, gated by any-grant
//  tx64_dwen     out  1    muxed src_dwen
//  busy          out  1    state != IDLE
//  tmo_err       out  1    sticky: a request timed out; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, src_gnt=0, tx_req=0, tx64_*=0, rr_ptr=0, ipg/tmo counters=0, tmo_err=0, busy=0.
//  eligible[0]=src_req[0]&cr_ok_p; eligible[1]=src_req[1]&cr_ok_np&tag_avail; eligible[2]=src_req[2].
//  FSM IDLE->REQ->XFER->GAP->IDLE:
//   IDLE: if |eligible: pick winner (CPL_PRIO&eligible[2] -> 2, else first eligible from rr_ptr upward, mod 3);
//         next cycle src_gnt=winner, tx_req=1, state REQ, rr_ptr=winner+1 (2 wraps to 0). No eligible -> stay.
//   REQ:  tx_req held 1. tx_rdy=1 -> tx_req=0 next cycle, state XFER. Credits are not re-checked after grant.
//         tmo counter increments; reaching TMO_CYC-1 without tx_rdy -> tx_req=0, src_gnt=0, tmo_err=1, IDLE.
//   XFER: tx64_* follow granted source combinationally. Each tx_val consumes one beat (src_rd).
//         tx_val & src_end[g] -> src_gnt=0 next cycle; IPG_CYC=0 -> IDLE, else load ipg=IPG_CYC, GAP.
//         tx_val & src_st & src_end same beat (single-beat TLP) is legal. No timeout, no abort in XFER.
//         src_req dropping mid-TLP is a source error; arbiter keeps grant until end beat.
//   GAP:  ipg decrements each cycle; at 1 -> IDLE. Requests ignored; tx64_st/end forced 0.
//  Latency: eligible in IDLE -> tx_req high 1 cycle later; min TLP-to-TLP spacing = IPG_CYC+2 cycles.
//  tx_rdy/tx_val outside REQ/XFER ignored. Simultaneous eligibility resolved only in IDLE.
//  Reset mid-TLP: all outputs return to reset values asynchronously; partial TLP handling is the FIFOs' job.
// STRUCTURE
//  sfif_pkg: state encodings (ST_IDLE/ST_REQ/ST_XFER/ST_GAP), source indices SRC_P=0/SRC_NP=1/SRC_CPL=2.
//  One sub-module: sfif_rr3 (3-way round-robin pick from rr_ptr with priority override), combinational.
//  Beat mux, FSM, counters inline.
// TESTING
//  Single P req, cr_ok_p=1, tx_rdy 3 cycles after tx_req, 4 beats -> src_gnt=001, 4 src_rd pulses, IDLE after GAP=4.
//  P,NP,CPL all eligible, CPL_PRIO=0, rr_ptr=0 -> grant order 0,1,2,0.
//  CPL_PRIO=1, all eligible repeatedly -> CPL served every arbitration while src_req[2]=1.
//  NP req with tag_avail=0 for 50 cycles -> no grant, tx_req=0; tag_avail=1 -> tx_req next cycle.
//  tx_rdy never asserted, TMO_CYC=16 -> tx_req drops after 16 cycles in REQ, tmo_err=1, next source arbitrated.
//  Assert sfif_rstn=0 during XFER beat 2 -> src_gnt=0, tx_req=0, busy=0 immediately; clean TLP after release.

Source files
------------

// File: rtl/sfif_tx_arb_pkg.sv
// Shared types for the SFIF TX arbiter: FSM states, source indices
// and the round-robin pointer advance helper.
package sfif_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   localparam int          NSRC    = 3;
   localparam logic [1:0]  SRC_P   = 2'd0;
   localparam logic [1:0]  SRC_NP  = 2'd1;
   localparam logic [1:0]  SRC_CPL = 2'd2;

   function automatic logic [1:0] rr_next(input logic [1:0] w);
      return (w == SRC_CPL) ? SRC_P : w + 2'd1;
   endfunction

endpackage

// File: rtl/sfif_tx_arb_rr3.sv
// 3-way round-robin pick starting at ptr_i, with an optional
// completion-first override. Purely combinational.
module sfif_tx_arb_rr3
   import sfif_tx_arb_pkg::*;
#(
   parameter bit CPL_PRIO = 1'b1
) (
   input  logic [2:0] elig_i,
   input  logic [1:0] ptr_i,
   output logic       any_o,
   output logic [1:0] idx_o,
   output logic [2:0] oh_o
);

   int cidx;

   always_comb begin
      any_o = |elig_i;
      idx_o = SRC_P;
      cidx  = 0;
      if (CPL_PRIO && elig_i[SRC_CPL]) begin
         idx_o = SRC_CPL;
      end else begin
         // walk backwards so the candidate nearest ptr_i is written last
         for (int k = 2; k >= 0; k--) begin
            cidx = (int'(ptr_i) + k) % 3;
            if (elig_i[cidx]) idx_o = 2'(cidx);
         end
      end
      oh_o = any_o ? (3'b001 << idx_o) : 3'b000;
   end

endmodule

// File: rtl/sfif_tx_arb.sv
// Arbitrates the shared 64-bit TX TLP path between posted, non-posted
// and completion sources; owns the path until end beat, then idles IPG.
module sfif_tx_arb
   import sfif_tx_arb_pkg::*;
#(
   parameter int unsigned IPG_CYC  = 4,
   parameter int unsigned TMO_CYC  = 1024,
   parameter bit          CPL_PRIO = 1'b1
) (
   input  logic         clk_125,
   input  logic         sfif_rstn,
   input  logic [2:0]   src_req,
   input  logic [191:0] src_data,
   input  logic [2:0]   src_st,
   input  logic [2:0]   src_end,
   input  logic [2:0]   src_dwen,
   output logic [2:0]   src_gnt,
   output logic [2:0]   src_rd,
   input  logic         cr_ok_p,
   input  logic         cr_ok_np,
   input  logic         tag_avail,
   output logic         tx_req,
   input  logic         tx_rdy,
   input  logic         tx_val,
   output logic [63:0]  tx64_data,
   output logic         tx64_st,
   output logic         tx64_end,
   output logic         tx64_dwen,
   output logic         busy,
   output logic         tmo_err
);

   localparam int IPGW = (IPG_CYC > 0) ? $clog2(IPG_CYC + 1) : 1;
   localparam int TMOW = $clog2(TMO_CYC + 1);

   state_e            state_q, state_d;
   logic [2:0]        gnt_q, gnt_d;
   logic              req_q, req_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [IPGW-1:0]   ipg_q, ipg_d;
   logic [TMOW-1:0]   tmo_q, tmo_d;
   logic              err_q, err_d;

   logic [2:0]        elig;
   logic              win_any;
   logic [1:0]        win_idx;
   logic [2:0]        win_oh;
   logic              end_hit;
   logic              tmo_hit;
   logic              ipg_last;

   assign elig[SRC_P]   = src_req[SRC_P] & cr_ok_p;
   assign elig[SRC_NP]  = src_req[SRC_NP] & cr_ok_np & tag_avail;
   assign elig[SRC_CPL] = src_req[SRC_CPL];

   sfif_tx_arb_rr3 #(
      .CPL_PRIO (CPL_PRIO)
   ) u_rr3 (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .any_o  (win_any),
      .idx_o  (win_idx),
      .oh_o   (win_oh)
   );

   assign end_hit  = tx_val & |(gnt_q & src_end);
   assign tmo_hit  = (tmo_q == TMOW'(TMO_CYC - 1));
   assign ipg_last = (ipg_q == IPGW'(1));

   always_ff @(posedge clk_125 or negedge sfif_rstn) begin
      if (!sfif_rstn) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         req_q   <= 1'b0;
         ptr_q   <= SRC_P;
         ipg_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         req_q   <= req_d;
         ptr_q   <= ptr_d;
         ipg_q   <= ipg_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (win_any) state_d = ST_REQ;
         ST_REQ: begin
            if (tx_rdy)       state_d = ST_XFER;
            else if (tmo_hit) state_d = ST_IDLE;
         end
         ST_XFER: begin
            if (end_hit)
               state_d = (IPG_CYC == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: if (ipg_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_d = gnt_q;
      req_d = req_q;
      ptr_d = ptr_q;
      ipg_d = ipg_q;
      tmo_d = tmo_q;
      err_d = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               gnt_d = win_oh;
               req_d = 1'b1;
               ptr_d = rr_next(win_idx);
               tmo_d = '0;
            end
         end
         ST_REQ: begin
            if (tx_rdy) begin
               req_d = 1'b0;
            end else if (tmo_hit) begin
               req_d = 1'b0;
               gnt_d = '0;
               err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + TMOW'(1);
            end
         end
         ST_XFER: begin
            // credits are not re-checked once the path is owned
            if (end_hit) begin
               gnt_d = '0;
               ipg_d = IPGW'(IPG_CYC);
            end
         end
         ST_GAP: ipg_d = ipg_q - IPGW'(1);
         default: ;
      endcase
   end

   always_comb begin
      tx64_data = '0;
      tx64_st   = 1'b0;
      tx64_end  = 1'b0;
      tx64_dwen = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (gnt_q[i]) begin
            tx64_data = tx64_data | src_data[i*64 +: 64];
            tx64_st   = tx64_st   | src_st[i];
            tx64_end  = tx64_end  | src_end[i];
            tx64_dwen = tx64_dwen | src_dwen[i];
         end
      end
   end

   assign src_gnt = gnt_q;
   assign src_rd  = gnt_q & {3{tx_val}};
   assign tx_req  = req_q;
   assign busy    = (state_q != ST_IDLE);
   assign tmo_err = err_q;

endmodule

// File: tb/tb_sfif_tx_arb.sv
// Bench for sfif_tx_arb: vector table, directed corner sequences and
// random traffic checked against a rule-level reference model.
module tb_sfif_tx_arb;

   localparam int IPG = 4;
   localparam int TMO = 16;

   logic         clk_125 = 1'b0;
   logic         sfif_rstn;
   logic [2:0]   src_req, src_st, src_end, src_dwen;
   logic [191:0] src_data;
   logic         cr_ok_p, cr_ok_np, tag_avail, tx_rdy, tx_val;

   logic [2:0]   a_gnt, a_rd, b_gnt, b_rd;
   logic         a_req, a_st, a_end, a_dwen, a_busy, a_tmo;
   logic         b_req, b_st, b_end, b_dwen, b_busy, b_tmo;
   logic [63:0]  a_data, b_data;
   logic [75:0]  out_a, out_b;

   int n_pass = 0;
   int n_tot  = 0;

   always #4 clk_125 = ~clk_125;

   sfif_tx_arb #(.IPG_CYC(IPG), .TMO_CYC(TMO), .CPL_PRIO(1'b0)) dut_a (
      .clk_125(clk_125), .sfif_rstn(sfif_rstn),
      .src_req(src_req), .src_data(src_data), .src_st(src_st),
      .src_end(src_end), .src_dwen(src_dwen),
      .src_gnt(a_gnt), .src_rd(a_rd),
      .cr_ok_p(cr_ok_p), .cr_ok_np(cr_ok_np), .tag_avail(tag_avail),
      .tx_req(a_req), .tx_rdy(tx_rdy), .tx_val(tx_val),
      .tx64_data(a_data), .tx64_st(a_st), .tx64_end(a_end),
      .tx64_dwen(a_dwen), .busy(a_busy), .tmo_err(a_tmo));

   sfif_tx_arb #(.IPG_CYC(IPG), .TMO_CYC(TMO), .CPL_PRIO(1'b1)) dut_b (
      .clk_125(clk_125), .sfif_rstn(sfif_rstn),
      .src_req(src_req), .src_data(src_data), .src_st(src_st),
      .src_end(src_end), .src_dwen(src_dwen),
      .src_gnt(b_gnt), .src_rd(b_rd),
      .cr_ok_p(cr_ok_p), .cr_ok_np(cr_ok_np), .tag_avail(tag_avail),
      .tx_req(b_req), .tx_rdy(tx_rdy), .tx_val(tx_val),
      .tx64_data(b_data), .tx64_st(b_st), .tx64_end(b_end),
      .tx64_dwen(b_dwen), .busy(b_busy), .tmo_err(b_tmo));

   assign out_a = {a_gnt, a_rd, a_req, a_st, a_end, a_dwen, a_busy, a_tmo, a_data};
   assign out_b = {b_gnt, b_rd, b_req, b_st, b_end, b_dwen, b_busy, b_tmo, b_data};

   // ph: 0 idle, 1 waiting for core, 2 moving beats, 3 gap
   typedef struct {
      int own;
      int ph;
      int cnt;
      int ptr;
      bit err;
   } mdl_t;

   mdl_t ma, mb;

   typedef struct {
      logic [2:0] req;
      logic       rdy;
      logic       val;
      logic [2:0] en;
      logic [2:0] gnt;
      logic       txreq;
      logic [2:0] rd;
      logic       busy;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic mdl_t mreset();
      mdl_t s;
      s.own = -1; s.ph = 0; s.cnt = 0; s.ptr = 0; s.err = 1'b0;
      return s;
   endfunction

   function automatic mdl_t mstep(input mdl_t s, input bit prio);
      logic [2:0] el;
      int w, c;
      el = {src_req[2], src_req[1] & cr_ok_np & tag_avail, src_req[0] & cr_ok_p};
      w = -1;
      case (s.ph)
         0: if (el != 3'b000) begin
            if (prio && el[2]) w = 2;
            else for (int k = 0; k < 3; k++) begin
               c = (s.ptr + k) % 3;
               if (w < 0 && el[c]) w = c;
            end
            s.own = w; s.ptr = (w + 1) % 3; s.ph = 1; s.cnt = 0;
         end
         1: if (tx_rdy) s.ph = 2;
            else if (s.cnt == TMO - 1) begin
               s.err = 1'b1; s.own = -1; s.ph = 0;
            end else s.cnt++;
         2: if (tx_val && src_end[s.own]) begin
            s.own = -1; s.ph = (IPG == 0) ? 0 : 3; s.cnt = IPG;
         end
         3: if (s.cnt == 1) s.ph = 0; else s.cnt--;
         default: s.ph = 0;
      endcase
      return s;
   endfunction

   function automatic logic [75:0] mexp(input mdl_t s);
      logic [2:0]  g;
      logic [63:0] d;
      logic        st, en, dw;
      g = '0; d = '0; st = 1'b0; en = 1'b0; dw = 1'b0;
      if (s.own >= 0) begin
         g  = 3'b001 << s.own;
         d  = src_data[s.own*64 +: 64];
         st = src_st[s.own];
         en = src_end[s.own];
         dw = src_dwen[s.own];
      end
      return {g, g & {3{tx_val}}, s.ph == 1, st, en, dw, s.ph != 0, s.err, d};
   endfunction

   // called just after a falling edge with inputs already driven
   task automatic cyc();
      #1;
      chk("mdl_a", out_a, mexp(ma));
      chk("mdl_b", out_b, mexp(mb));
      @(posedge clk_125);
      if (sfif_rstn) begin
         ma = mstep(ma, 1'b0);
         mb = mstep(mb, 1'b1);
      end
      @(negedge clk_125);
   endtask

   task automatic idle_inputs();
      src_req = '0; src_st = '0; src_end = '0; src_dwen = '0;
      src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cr_ok_p = 1'b0; cr_ok_np = 1'b0; tag_avail = 1'b0;
      tx_rdy = 1'b0; tx_val = 1'b0;
   endtask

   task automatic hard_reset();
      sfif_rstn = 1'b0;
      ma = mreset();
      mb = mreset();
      @(negedge clk_125);
      @(negedge clk_125);
      sfif_rstn = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] qa[$], qb[$];
      logic [2:0] ea[4], eb[4];
      int hi, n, rd;

      tbl[0]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};
      tbl[1]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b1};
      tbl[2]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b1};
      tbl[3]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b1};
      tbl[4]  = '{3'b001, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b1};
      tbl[5]  = '{3'b001, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 3'b001, 1'b1};
      tbl[6]  = '{3'b001, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 3'b001, 1'b1};
      tbl[7]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 3'b000, 1'b1};
      tbl[8]  = '{3'b001, 1'b0, 1'b1, 3'b000, 3'b001, 1'b0, 3'b001, 1'b1};
      tbl[9]  = '{3'b001, 1'b0, 1'b1, 3'b001, 3'b001, 1'b0, 3'b001, 1'b1};
      tbl[10] = '{3'b001, 1'b1, 1'b1, 3'b001, 3'b000, 1'b0, 3'b000, 1'b1};
      tbl[11] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1};
      tbl[12] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1};
      tbl[13] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1};
      tbl[14] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0};
      tbl[15] = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b1};
      ea = '{3'b001, 3'b010, 3'b100, 3'b001};
      eb = '{3'b100, 3'b100, 3'b100, 3'b100};

      idle_inputs();
      @(negedge clk_125);
      hard_reset();
      #1;
      chk("reset_state", out_a, 76'h0);

      // single posted TLP: 4 beats, tx_rdy 3 cycles late, 4-cycle gap
      cr_ok_p = 1'b1;
      for (int i = 0; i < 16; i++) begin
         src_req = tbl[i].req;
         tx_rdy  = tbl[i].rdy;
         tx_val  = tbl[i].val;
         src_end = tbl[i].en;
         src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         #1;
         chk($sformatf("tbl%0d", i), 76'({a_gnt, a_req, a_rd, a_busy}),
             76'({tbl[i].gnt, tbl[i].txreq, tbl[i].rd, tbl[i].busy}));
         cyc();
      end

      // round robin vs completion priority, everything eligible
      idle_inputs();
      hard_reset();
      src_req = 3'b111; cr_ok_p = 1'b1; cr_ok_np = 1'b1; tag_avail = 1'b1;
      src_st = 3'b111; src_end = 3'b111; tx_rdy = 1'b1; tx_val = 1'b1;
      for (int c = 0; c < 40 && qa.size() < 4; c++) begin
         if (a_req) qa.push_back(a_gnt);
         if (b_req) qb.push_back(b_gnt);
         cyc();
      end
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_order%0d", k), (qa.size() > k) ? 76'(qa[k]) : 'x, 76'(ea[k]));
         chk($sformatf("cpl_prio%0d", k), (qb.size() > k) ? 76'(qb[k]) : 'x, 76'(eb[k]));
      end

      // non-posted blocked by tag, then timeout
      idle_inputs();
      hard_reset();
      src_req = 3'b010; cr_ok_p = 1'b1; cr_ok_np = 1'b1;
      hi = 0;
      for (int c = 0; c < 50; c++) begin
         if (a_req || a_gnt != 3'b000) hi++;
         cyc();
      end
      chk("np_blocked", 76'(hi), 76'(0));
      tag_avail = 1'b1;
      #1;
      chk("np_same_cyc", 76'(a_req), 76'(0));
      cyc();
      chk("np_req", 76'({a_req, a_gnt}), 76'(4'b1010));
      src_req = 3'b011; tag_avail = 1'b0;
      n = 0;
      while (a_req && n < 100) begin
         n++;
         cyc();
      end
      chk("tmo_len", 76'(n), 76'(TMO));
      chk("tmo_flag", 76'({a_tmo, a_gnt, a_busy}), 76'(5'b1_000_0));
      cyc();
      chk("tmo_next", 76'({a_req, a_gnt, a_tmo}), 76'(5'b1_001_1));

      // asynchronous reset during the second data beat
      idle_inputs();
      hard_reset();
      src_req = 3'b001; cr_ok_p = 1'b1; tx_rdy = 1'b1;
      cyc();
      cyc();
      tx_val = 1'b1;
      cyc();
      #1;
      sfif_rstn = 1'b0;
      ma = mreset();
      mb = mreset();
      #1;
      chk("rst_async", 76'({a_gnt, a_req, a_busy, a_rd, a_tmo}), 76'(0));
      @(posedge clk_125);
      @(negedge clk_125);
      sfif_rstn = 1'b1;
      rd = 0;
      for (int c = 0; c < 20; c++) begin
         src_end = (rd == 2) ? 3'b001 : 3'b000;
         src_req = (rd < 3) ? 3'b001 : 3'b000;
         #1;
         if (a_rd[0]) rd++;
         cyc();
      end
      chk("clean_beats", 76'(rd), 76'(3));
      chk("clean_idle", 76'({a_busy, a_gnt}), 76'(0));

      // random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         src_req  = 3'($urandom);
         src_st   = 3'($urandom);
         src_end  = 3'($urandom & $urandom);
         src_dwen = 3'($urandom);
         src_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         cr_ok_p   = ($urandom_range(0, 3) != 0);
         cr_ok_np  = ($urandom_range(0, 3) != 0);
         tag_avail = ($urandom_range(0, 3) != 0);
         tx_rdy    = ($urandom_range(0, 7) == 0);
         tx_val    = 1'($urandom);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
